// File: rtl/isa_pkg.sv
// Shared definitions for the custom 10-bit ISA front end.
//
// Contents:
//   INSTR_W, IMEM_DEPTH, PC_W  default widths/depth used by the fetch unit
//   OPC_HALT                   full-word encoding of HALT (all zeros)
//   OPC_JUMP, OPC_BEQ          4-bit major opcodes in bits [9:6]
//   JUMP_TGT_MSB/LSB           bounds of the JUMP absolute target field
//   fetch_state_e              fetch FSM states
//   is_jump_op()               major-opcode test for JUMP
package isa_pkg;

    localparam int INSTR_W    = 10;
    localparam int IMEM_DEPTH = 64;
    localparam int PC_W       = 10;

    localparam logic [INSTR_W-1:0] OPC_HALT = 10'b0;
    localparam logic [3:0]         OPC_JUMP = 4'b1001;
    localparam logic [3:0]         OPC_BEQ  = 4'b1000;

    localparam int OPC_MSB      = 9;
    localparam int OPC_LSB      = 6;
    localparam int JUMP_TGT_MSB = 5;
    localparam int JUMP_TGT_LSB = 0;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    function automatic logic is_jump_op(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OPC_JUMP;
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter for the fetch stage.
//
// Holds the PC and selects the next value with priority
// reset > redirect > predecoded jump > increment > hold.
// Every new value is reduced modulo IMEM_DEPTH (a power of two), so the
// bits above log2(IMEM_DEPTH) are always zero.
//
// Ports:
//   clk_i              clock, rising edge
//   rst_n_i            synchronous active-low reset (PC -> 0)
//   redirect_i         load redirect_target_i
//   redirect_target_i  redirect destination (reduced modulo depth)
//   jump_i             load jump_target_i (fetch-side predecoded JUMP)
//   jump_target_i      jump destination (reduced modulo depth)
//   advance_i          increment with wrap
//   pc_o               current PC
module program_counter #(
    parameter int IMEM_DEPTH = 64,
    parameter int PC_W       = 10
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_target_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic            advance_i,
    output logic [PC_W-1:0] pc_o
);

    localparam logic [PC_W-1:0] PC_MASK = PC_W'(IMEM_DEPTH - 1);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_target_i & PC_MASK;
        end else if (jump_i) begin
            pc_d = jump_target_i & PC_MASK;
        end else if (advance_i) begin
            pc_d = (pc_q + PC_W'(1)) & PC_MASK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the custom 10-bit ISA.
//
// Drives the instruction-memory read address from the PC, captures the
// asynchronously returned word into a one-entry instruction slot (IR) that
// decode accepts through IR_VALID/IR_READY, detects HALT (all-zero word)
// and follows redirects from execute.
//
// Optional build macro: JUMP_PREDECODE_EN
//   defined   - JUMP words are consumed in fetch and steer the PC directly;
//               they never reach IR and are not counted.
//   undefined - JUMP is forwarded like any other instruction.
//
// Ports:
//   CLK              clock, rising edge
//   RST_N            synchronous active-low reset
//   ADDRESS          instruction-memory read address (= PC)
//   INSTRUCTION      asynchronous read data for ADDRESS
//   IR / IR_PC       registered instruction and the address it came from
//   IR_VALID         IR holds an instruction not yet accepted
//   IR_READY         decode accepts IR this cycle
//   REDIRECT         execute requests a PC change
//   REDIRECT_TARGET  new PC (reduced modulo IMEM_DEPTH)
//   HALTED           HALT fetched, fetch stopped
//   FETCH_COUNT      completed IR handshakes, saturating
module instruction_fetch_unit #(
    parameter int IMEM_DEPTH = isa_pkg::IMEM_DEPTH,
    parameter int INSTR_W    = isa_pkg::INSTR_W,
    parameter int PC_W       = isa_pkg::PC_W,
    parameter int CNT_W      = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    output logic [PC_W-1:0]    ADDRESS,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    output logic [INSTR_W-1:0] IR,
    output logic [PC_W-1:0]    IR_PC,
    output logic               IR_VALID,
    input  logic               IR_READY,
    input  logic               REDIRECT,
    input  logic [PC_W-1:0]    REDIRECT_TARGET,
    output logic               HALTED,
    output logic [CNT_W-1:0]   FETCH_COUNT
);

    import isa_pkg::*;

    fetch_state_e       state_q;
    logic [INSTR_W-1:0] ir_q;
    logic [PC_W-1:0]    ir_pc_q;
    logic               ir_valid_q;
    logic [CNT_W-1:0]   fetch_count_q;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    jump_target;
    logic               acc;
    logic               load;
    logic               is_halt;
    logic               jump_take;
    logic               advance;

    assign acc     = ir_valid_q & IR_READY;
    // The slot can take a new word when it is empty or being drained now.
    assign load    = (state_q == FETCH_RUN) & (~ir_valid_q | IR_READY);
    assign is_halt = (INSTRUCTION == OPC_HALT);

    assign jump_target = PC_W'(INSTRUCTION[JUMP_TGT_MSB:JUMP_TGT_LSB]);

`ifdef JUMP_PREDECODE_EN
    assign jump_take = load & ~REDIRECT & is_jump_op(INSTRUCTION);
`else
    assign jump_take = 1'b0;
`endif

    // HALT freezes the PC on the HALT address; a jump is handled by the
    // jump path inside the PC instead of the increment.
    assign advance = load & ~is_halt & ~jump_take;

    program_counter #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .PC_W       (PC_W)
    ) u_program_counter (
        .clk_i             (CLK),
        .rst_n_i           (RST_N),
        .redirect_i        (REDIRECT),
        .redirect_target_i (REDIRECT_TARGET),
        .jump_i            (jump_take),
        .jump_target_i     (jump_target),
        .advance_i         (advance),
        .pc_o              (pc)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= FETCH_RUN;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else if (REDIRECT) begin
            // Flush: whatever is on INSTRUCTION this cycle belongs to the
            // wrong path, including a speculatively fetched HALT.
            state_q    <= FETCH_RUN;
            ir_valid_q <= 1'b0;
        end else if (jump_take) begin
            // JUMP consumed in fetch; IR/IR_PC keep their old contents.
            ir_valid_q <= 1'b0;
        end else if (load) begin
            ir_q       <= INSTRUCTION;
            ir_pc_q    <= pc;
            ir_valid_q <= 1'b1;
            if (is_halt) begin
                state_q <= FETCH_HALTED;
            end
        end else if (acc) begin
            // Only reachable while halted: the HALT word drains out.
            ir_valid_q <= 1'b0;
        end
    end

    // Handshakes count even when a redirect flushes the slot that cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            fetch_count_q <= '0;
        end else if (acc && (fetch_count_q != '1)) begin
            fetch_count_q <= fetch_count_q + CNT_W'(1);
        end
    end

    assign ADDRESS     = pc;
    assign IR          = ir_q;
    assign IR_PC       = ir_pc_q;
    assign IR_VALID    = ir_valid_q;
    assign HALTED      = (state_q == FETCH_HALTED);
    assign FETCH_COUNT = fetch_count_q;

endmodule
